// File: rtl/ifq_pkg.sv
// Shared constants and entry layout for the IF/ID fetch queue.
// Optional feature macro used by the queue: IFQ_BYPASS_EN.
package ifq_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
   localparam int          DEFAULT_DEPTH = 4;

   // Entry layout at the default 32-bit datapath width.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF/ID queue: synchronous write, asynchronous read, no reset.
// Contents are don't-care after reset; occupancy lives in the parent.
module ifq_storage #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [W-1:0]             o_rdata
);

   logic [W-1:0] mem_r [DEPTH];

   // Write the accepted fetch word into its slot.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_r[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_r[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: buffers {pc, instr} toward decode with back-pressure to fetch and redirect flush.
// Optional zero-latency bypass on an empty queue: define IFQ_BYPASS_EN.
module if_id_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int DATA_W = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [DATA_W-1:0]        i_fetch_pc,
   input  logic [DATA_W-1:0]        i_fetch_instr,
   input  logic                     i_flush,
   output logic                     o_pcWrite,
   output logic                     o_id_valid,
   input  logic                     i_id_ready,
   output logic [DATA_W-1:0]        o_id_pc,
   output logic [DATA_W-1:0]        o_id_instr,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;
   logic                full_s;
   logic                empty_s;
   logic                bypass_s;
   logic                pcwrite_s;
   logic                push_s;
   logic                pop_s;
   logic [2*DATA_W-1:0] rd_data_s;

   // Handshake decode; flush dominates, and full depends only on registered count.
   always_comb begin
      full_s    = (count_r == CW'(DEPTH));
      empty_s   = (count_r == {CW{1'b0}});
`ifdef IFQ_BYPASS_EN
      bypass_s  = empty_s && i_id_ready && !i_flush;
`else
      bypass_s  = 1'b0;
`endif
      pcwrite_s = !full_s && !i_flush;
      push_s    = pcwrite_s && !bypass_s;
      pop_s     = !empty_s && i_id_ready && !i_flush;
   end

   ifq_storage #(
      .DEPTH (DEPTH),
      .W     (2*DATA_W)
   ) u_storage (
      .i_clk   (i_clk),
      .i_we    (push_s),
      .i_waddr (wr_ptr_r),
      .i_wdata ({i_fetch_pc, i_fetch_instr}),
      .i_raddr (rd_ptr_r),
      .o_rdata (rd_data_s)
   );

   // Pointers and occupancy; pointers wrap naturally, count separates full from empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (i_flush) begin
         rd_ptr_r <= wr_ptr_r;
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head presentation: first-word-fall-through, NOP when empty unless bypassing.
   always_comb begin
      o_pcWrite = pcwrite_s;
      o_count   = count_r;
      if (!empty_s) begin
         o_id_valid = 1'b1;
         o_id_pc    = rd_data_s[2*DATA_W-1:DATA_W];
         o_id_instr = rd_data_s[DATA_W-1:0];
      end else if (bypass_s) begin
         o_id_valid = 1'b1;
         o_id_pc    = i_fetch_pc;
         o_id_instr = i_fetch_instr;
      end else begin
         o_id_valid = 1'b0;
         o_id_pc    = {DATA_W{1'b0}};
         o_id_instr = DATA_W'(NOP_INSTR);
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed table-driven bench for if_id_queue (DEPTH=4, DATA_W=32), plus
// hand-written flush, async-reset and empty-queue latency sequences.
module tb_if_id_queue;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        flush;
   logic        pc_write;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   if_id_queue #(.DEPTH(4), .DATA_W(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_fetch_pc    (fetch_pc),
      .i_fetch_instr (fetch_instr),
      .i_flush       (flush),
      .o_pcWrite     (pc_write),
      .o_id_valid    (id_valid),
      .i_id_ready    (id_ready),
      .o_id_pc       (id_pc),
      .o_id_instr    (id_instr),
      .o_count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        fl;
      logic [31:0] pc;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [2:0]  e_count;
      logic        e_pcw;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return 32'h2008_0005 ^ (pc << 16);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic set_vec(input int i, input logic rdy, input logic fl, input logic [31:0] pc,
                          input logic ev, input logic [31:0] epc, input logic [2:0] ecnt,
                          input logic epcw);
      vecs[i].rdy     = rdy;
      vecs[i].fl      = fl;
      vecs[i].pc      = pc;
      vecs[i].e_valid = ev;
      vecs[i].e_pc    = epc;
      vecs[i].e_instr = ev ? ins(epc) : 32'h0000_0000;
      vecs[i].e_count = ecnt;
      vecs[i].e_pcw   = epcw;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pcwrite"}, {31'd0, pc_write}, 32'd1);
      chk({tag, "_valid"},   {31'd0, id_valid}, 32'd0);
      chk({tag, "_count"},   {29'd0, count},    32'd0);
      chk({tag, "_pc"},      id_pc,             32'd0);
      chk({tag, "_instr"},   id_instr,          32'd0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      flush    = 1'b0;
      id_ready = 1'b0;
      fetch_pc = 32'd0;
      fetch_instr = ins(32'd0);
      #1;
      chk_reset_vals("reset");
      flush = 1'b1;           // hold flush so no stray push while idling
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Pre-edge expectations for inputs applied on each negedge (rdy, flush, pc -> valid, head pc, count, pcWrite).
      set_vec( 0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  3'd0, 1'b1);
      set_vec( 1, 1'b0, 1'b0, 32'd1,  1'b1, 32'd0,  3'd1, 1'b1);
      set_vec( 2, 1'b1, 1'b0, 32'd2,  1'b1, 32'd0,  3'd2, 1'b1);
      set_vec( 3, 1'b1, 1'b0, 32'd3,  1'b1, 32'd1,  3'd2, 1'b1);
      set_vec( 4, 1'b1, 1'b0, 32'd4,  1'b1, 32'd2,  3'd2, 1'b1);
      set_vec( 5, 1'b1, 1'b0, 32'd5,  1'b1, 32'd3,  3'd2, 1'b1);
      set_vec( 6, 1'b1, 1'b0, 32'd6,  1'b1, 32'd4,  3'd2, 1'b1);
      set_vec( 7, 1'b1, 1'b0, 32'd7,  1'b1, 32'd5,  3'd2, 1'b1);
      set_vec( 8, 1'b0, 1'b0, 32'd8,  1'b1, 32'd6,  3'd2, 1'b1);
      set_vec( 9, 1'b0, 1'b0, 32'd9,  1'b1, 32'd6,  3'd3, 1'b1);
      set_vec(10, 1'b0, 1'b0, 32'd10, 1'b1, 32'd6,  3'd4, 1'b0);
      set_vec(11, 1'b1, 1'b0, 32'd10, 1'b1, 32'd6,  3'd4, 1'b0);
      set_vec(12, 1'b1, 1'b0, 32'd10, 1'b1, 32'd7,  3'd3, 1'b1);
      set_vec(13, 1'b1, 1'b0, 32'd11, 1'b1, 32'd8,  3'd3, 1'b1);
      set_vec(14, 1'b1, 1'b1, 32'h99, 1'b1, 32'd9,  3'd3, 1'b0);
      set_vec(15, 1'b0, 1'b0, 32'h40, 1'b0, 32'd0,  3'd0, 1'b1);
      set_vec(16, 1'b0, 1'b0, 32'h41, 1'b1, 32'h40, 3'd1, 1'b1);
      set_vec(17, 1'b0, 1'b0, 32'h42, 1'b1, 32'h40, 3'd2, 1'b1);

      do_reset();

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         id_ready    = vecs[i].rdy;
         flush       = vecs[i].fl;
         fetch_pc    = vecs[i].pc;
         fetch_instr = ins(vecs[i].pc);
         #1;
         chk($sformatf("v%0d_valid", i),   {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_pc", i),      id_pc,             vecs[i].e_pc);
         chk($sformatf("v%0d_instr", i),   id_instr,          vecs[i].e_instr);
         chk($sformatf("v%0d_count", i),   {29'd0, count},    {29'd0, vecs[i].e_count});
         chk($sformatf("v%0d_pcwrite", i), {31'd0, pc_write}, {31'd0, vecs[i].e_pcw});
      end

      // Async reset between edges with three entries held (0x40..0x42).
      @(negedge clk);
      id_ready = 1'b0;
      flush    = 1'b1;
      #1;
      chk("pre_areset_count", {29'd0, count}, 32'd3);
      chk("pre_areset_head",  id_pc,          32'h40);
      #1;
      rst_n = 1'b0;
      flush = 1'b0;
      #1;
      chk_reset_vals("areset");
      flush = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Empty queue, decode ready, pc=7 presented.
      @(negedge clk);
      flush       = 1'b0;
      id_ready    = 1'b1;
      fetch_pc    = 32'd7;
      fetch_instr = ins(32'd7);
      #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_valid", {31'd0, id_valid}, 32'd1);
      chk("byp_pc",    id_pc,             32'd7);
      chk("byp_instr", id_instr,          ins(32'd7));
`else
      chk("byp_valid", {31'd0, id_valid}, 32'd0);
      chk("byp_pc",    id_pc,             32'd0);
`endif
      chk("byp_count",   {29'd0, count},    32'd0);
      chk("byp_pcwrite", {31'd0, pc_write}, 32'd1);
      @(negedge clk);
      id_ready    = 1'b0;
      fetch_pc    = 32'd8;
      fetch_instr = ins(32'd8);
      #1;
`ifdef IFQ_BYPASS_EN
      chk("byp_next_valid", {31'd0, id_valid}, 32'd0);
      chk("byp_next_count", {29'd0, count},    32'd0);
`else
      chk("byp_next_valid", {31'd0, id_valid}, 32'd1);
      chk("byp_next_pc",    id_pc,             32'd7);
      chk("byp_next_instr", id_instr,          ins(32'd7));
      chk("byp_next_count", {29'd0, count},    32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receive side of the fetch interface: captures the PC and instruction produced by the fetch stage each cycle and buffers them in a small FIFO toward decode.
- Drives the fetch stage's PC-write enable as back-pressure, so fetch advances only when an entry is actually accepted.
- Sits between the fetch stage and decode, replacing a bare IF/ID register. Adds a valid/ready handshake to decode and a flush for branch/jump redirects.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, 2..16
- DATA_W, 32, width of PC and instruction fields

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous reset, active-low
- i_fetch_pc  input  DATA_W  PC currently presented by fetch
- i_fetch_instr  input  DATA_W  instruction at i_fetch_pc (combinational ROM output)
- i_flush  input  1  redirect taken (same cycle the fetch PC mux selects the execute target); discard all entries
- o_pcWrite  output  1  to fetch: 1 = word accepted this edge, fetch advances PC
- o_id_valid  output  1  head entry valid toward decode
- i_id_ready  input  1  decode consumes head this edge when o_id_valid=1
- o_id_pc  output  DATA_W  head PC
- o_id_instr  output  DATA_W  head instruction
- o_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, i_rst_n=0):
  - write/read pointers=0, count=0
  - o_id_valid=0, o_id_pc=0, o_id_instr=0 (NOP)
  - o_pcWrite=1
  - storage contents are don't-care
- Occupancy and outputs:
  - full = (count==DEPTH)
  - o_pcWrite = !full && !i_flush (combinational)
  - o_id_valid = (count!=0)
  - o_id_pc/o_id_instr show head entry first-word-fall-through; forced to 0 when empty
- Push: o_pcWrite=1 at a rising edge → {i_fetch_pc, i_fetch_instr} written at write pointer; pointer increments modulo DEPTH.
- Pop: o_id_valid && i_id_ready && !i_flush at an edge → read pointer increments modulo DEPTH.
- Simultaneous push+pop: count unchanged, both pointers advance.
- Pop when full frees a slot for the following cycle only; no same-cycle push on full (o_pcWrite depends only on registered count).
- Latency: fetch word accepted at edge N is visible on o_id_* after edge N (one cycle). Order is strictly preserved.
- Flush:
  - at the next edge, count=0 and read pointer=write pointer
  - no push and no pop that cycle; i_id_ready is ignored
  - o_id_valid=0 the cycle after
  - flush beats any simultaneous push/pop
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; count is kept separately to distinguish full from empty.
- Reset asserted mid-operation: all entries lost immediately, outputs take their reset values asynchronously.
- Control: no FSM beyond the count; states are EMPTY / PARTIAL / FULL, derived from count.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When count==0, i_id_ready=1 and !i_flush, the incoming fetch word drives o_id_pc/o_id_instr combinationally, with o_id_valid=1.
  - The word is consumed without being stored; o_pcWrite=1, count stays 0. Zero-cycle latency.
- Undefined: no bypass; minimum latency is one cycle.

Decomposition:
- Package ifq_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - DEFAULT_DEPTH = 4
  - entry struct {pc, instr}
- One sub-module, ifq_storage: DEPTH×(2·DATA_W) register array, synchronous write, asynchronous read, no reset.
- Pointers, count, handshake and flush logic stay in if_id_queue.

Test Plan:
- Reset: hold i_rst_n=0 → o_pcWrite=1, o_id_valid=0, o_count=0, o_id_instr=0. Release, present pc=0/instr=32'h2008_0005 with i_id_ready=0 → after 1 edge o_id_valid=1, o_id_pc=0, o_id_instr=32'h2008_0005.
- Fill: i_id_ready=0, fetch pc 0,1,2,3,4 → o_count reaches 4, o_pcWrite=0, pc=4 not stored. Raise i_id_ready → outputs 0,1,2,3 in order, then pc=4 accepted.
- Concurrent: count=2, push and pop on the same edge for 6 cycles → o_count stays 2. Pointers wrap past DEPTH-1 with order intact.
- Flush: count=3, assert i_flush with i_id_ready=1 and a fetch word pending → next cycle o_count=0, o_id_valid=0, no entry consumed or written. Next push (pc=32'h40) appears at head.
- Async reset mid-stream: count=3, pulse i_rst_n low between edges → outputs go to reset values immediately, before the next clock.
- IFQ_BYPASS_EN: empty queue, i_id_ready=1, fetch pc=7 → same cycle o_id_valid=1, o_id_pc=7, o_count stays 0. Without the macro → o_id_valid=0 that cycle, pc=7 visible next cycle.
